relu_grad_unit: RTL and testbench
=================================

Name: relu_grad_unit

Overview:
Backward-pass companion to the 8-bit ReLU activation stage.
- Forward side: records one mask bit per sample accepted on the forward stream. Mask = 1 when the pre-activation is strictly positive.
- Mask storage: a DEPTH-entry FIFO.
- Backward side: for each incoming gradient, pops one mask bit and gates the gradient. The gradient passes when mask = 1, else it is zeroed.
- Sits between the activation stage and the gradient pipeline of the training datapath.

Parameters:
DEPTH, 16, number of mask entries; power of two, minimum 2.
LEAK_SHIFT, 3, right-shift applied to negative-region gradient; used only when RELU_GRAD_LEAKY_EN is defined.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous, active-high reset; sampled on rising clk; 1 = reset.
fwd_valid  input  1  forward sample present.
fwd_data  input  8  signed (two's complement) pre-activation value.
fwd_ready  output  1  mask FIFO can accept; equals !full.
grad_valid  input  1  gradient present.
grad_in  input  8  signed upstream gradient.
grad_ready  output  1  a mask is available; equals !empty.
grad_out  output  8  gated gradient, registered.
grad_out_valid  output  1  one-cycle pulse, high the cycle after a gradient is accepted.
level  output  $clog2(DEPTH)+1  current mask count.

Behaviour:
- Reset (rst_n = 1 at a rising edge) clears all of the following:
  - write pointer, read pointer and count to 0;
  - grad_out to 8'h00 and grad_out_valid to 0.
  - After reset: fwd_ready = 1, grad_ready = 0, level = 0.
- Reset mid-operation discards all stored masks. Any handshake in the reset cycle is ignored.
- Push:
  - Occurs when fwd_valid && fwd_ready.
  - Stored bit = (fwd_data[7] == 0) && (fwd_data != 0). Zero input stores 0.
- Pop:
  - Occurs when grad_valid && grad_ready.
  - On the next rising edge:
    - grad_out = mask ? grad_in : 8'h00;
    - grad_out_valid = 1.
  - Latency is 1 cycle from acceptance to grad_out_valid.
- No pop: grad_out holds its previous value and grad_out_valid = 0.
- Stall conditions:
  - grad_valid while empty is a stall, not an error: no pop and no output change.
  - fwd_valid while full is a stall: the sample is not recorded, and the producer must hold it.
- fwd_ready and grad_ready are derived from the registered count only. There is no combinational path from the valid inputs.
- Simultaneous push and pop in one cycle:
  - Both occur when both are allowed by the current count; count is unchanged.
  - At full, only the pop occurs, because fwd_ready = 0.
  - At empty, only the push occurs, because grad_ready = 0.
  - A mask pushed this cycle is poppable next cycle at the earliest.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0. Count is tracked separately, range 0..DEPTH.
- Ordering is strict FIFO: the Nth gradient accepted uses the Nth mask recorded since reset.
- No arithmetic on the pass path; the value is passed bit-exact.

Optional Feature:
RELU_GRAD_LEAKY_EN
- Defined: when mask = 0, grad_out = grad_in >>> LEAK_SHIFT (arithmetic shift, sign preserved, truncated toward negative infinity). Example: grad_in = 8'hE0 (-32), LEAK_SHIFT = 3 gives 8'hFC (-4).
- Undefined: when mask = 0, grad_out = 8'h00. LEAK_SHIFT is unused.
- The mask = 1 path is identical in both builds.

Test Plan:
1. Reset, then push fwd_data 8'h05, 8'hFB, 8'h00. Then pop grad_in 8'h10, 8'h20, 8'h30.
   Required: grad_out = 8'h10, 8'h00, 8'h00, each with a 1-cycle grad_out_valid pulse; level 3 -> 0.
2. Push 16 values of 8'h01.
   Required: fwd_ready = 0 and level = 16. A 17th fwd_valid is not recorded.
   Then pop 16: all pass grad_in unchanged, and fwd_ready returns to 1 after the first pop.
3. Assert grad_valid with grad_in 8'h7F while empty for 5 cycles.
   Required: grad_ready = 0, grad_out_valid stays 0, grad_out holds its value.
4. Fill to full, then hold fwd_valid and grad_valid together for 4 cycles.
   Required: cycle 1 pops only (level 15). Following cycles push and pop together, level stays 15.
5. Fill 10 entries, assert rst_n for 1 cycle mid-stream.
   Required: level = 0, grad_ready = 0, grad_out = 8'h00, grad_out_valid = 0. The next push/pop pair behaves as after a fresh reset.
6. With RELU_GRAD_LEAKY_EN defined, push 8'h80, then pop grad_in 8'hE0.
   Required: grad_out = 8'hFC. Without the macro, required grad_out = 8'h00.

Source files
------------

// File: rtl/relu_grad_unit_if.sv
// Forward-sample and backward-gradient handshake bundle for relu_grad_unit.
// master = activation/gradient pipeline side, slave = the mask unit.
interface relu_grad_unit_if #(
    parameter int DEPTH = 16
);
    logic                     fwd_valid;
    logic [7:0]               fwd_data;
    logic                     fwd_ready;
    logic                     grad_valid;
    logic [7:0]               grad_in;
    logic                     grad_ready;
    logic [7:0]               grad_out;
    logic                     grad_out_valid;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output fwd_valid, fwd_data, grad_valid, grad_in,
        input  fwd_ready, grad_ready, grad_out, grad_out_valid, level
    );

    modport slave (
        input  fwd_valid, fwd_data, grad_valid, grad_in,
        output fwd_ready, grad_ready, grad_out, grad_out_valid, level
    );
endinterface

// File: rtl/relu_grad_unit.sv
// ReLU backward-pass gate: a FIFO of forward "positive" mask bits gates incoming gradients.
// Define RELU_GRAD_LEAKY_EN to pass negative-region gradients as grad_in >>> LEAK_SHIFT instead of zero.
module relu_grad_unit #(
    parameter int DEPTH      = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    relu_grad_unit_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("relu_grad_unit: DEPTH must be a power of two >= 2");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_W) begin : g_bad_shift
        $error("relu_grad_unit: LEAK_SHIFT out of range");
    end

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     mask_mem [DEPTH];
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic signed [DATA_W-1:0] fwd_s_p0;
    logic signed [DATA_W-1:0] grad_s_p0;
    logic                     mask_wr_p0;
    logic                     mask_rd_p0;
    logic signed [DATA_W-1:0] grad_p1;
    logic                     vld_p1;

    function automatic logic signed [DATA_W-1:0] gate_grad(
        input logic                     m,
        input logic signed [DATA_W-1:0] g
    );
        logic signed [DATA_W-1:0] r;
        if (m) begin
            r = g;
        end else begin
`ifdef RELU_GRAD_LEAKY_EN
            r = g >>> LEAK_SHIFT;
`else
            r = '0;
`endif
        end
        return r;
    endfunction

    // Stage p0: handshake decode from registered count, mask capture and lookup
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push       = bus.fwd_valid && !full;
    assign pop        = bus.grad_valid && !empty;
    assign fwd_s_p0   = bus.fwd_data;
    assign grad_s_p0  = bus.grad_in;
    assign mask_wr_p0 = (fwd_s_p0 > 8'sd0);
    assign mask_rd_p0 = mask_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= mask_wr_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: registered gated gradient; holds its value when nothing is popped
    always_ff @(posedge clk) begin
        if (rst_n) begin
            grad_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                grad_p1 <= gate_grad(mask_rd_p0, grad_s_p0);
            end
        end
    end

    assign bus.fwd_ready      = !full;
    assign bus.grad_ready     = !empty;
    assign bus.grad_out       = grad_p1;
    assign bus.grad_out_valid = vld_p1;
    assign bus.level          = count;
endmodule

// File: tb/tb_relu_grad_unit.sv
// Scoreboard bench for relu_grad_unit: masks and expected gradients are queued as stimulus is driven.
module tb_relu_grad_unit;
    localparam int DEPTH      = 16;
    localparam int LEAK_SHIFT = 3;

    logic clk = 1'b0;
    logic rst_n;

    relu_grad_unit_if #(.DEPTH(DEPTH)) bus ();

    relu_grad_unit #(.DEPTH(DEPTH), .LEAK_SHIFT(LEAK_SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_cnt;
    bit         mask_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_out;
    logic [7:0] exp_v;
    bit         exp_vld;

    function automatic logic [7:0] model_grad(input bit m, input logic [7:0] gi);
        logic signed [7:0] g;
        g = gi;
        if (m) return gi;
`ifdef RELU_GRAD_LEAKY_EN
        return 8'(g >>> LEAK_SHIFT);
`else
        return 8'h00;
`endif
    endfunction

    // Drives one cycle of stimulus, updating the reference model from its own count.
    task automatic step(input bit fv, input logic [7:0] fd, input bit gv, input logic [7:0] gi);
        bit push_ok, pop_ok;
        bus.fwd_valid  = fv;
        bus.fwd_data   = fd;
        bus.grad_valid = gv;
        bus.grad_in    = gi;
        push_ok = fv && (model_cnt < DEPTH);
        pop_ok  = gv && (model_cnt > 0);
        if (pop_ok) exp_q.push_back(model_grad(mask_q.pop_front(), gi));
        if (push_ok) mask_q.push_back($signed(fd) > 8'sd0);
        model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
        exp_vld = pop_ok;
        @(posedge clk);
        #1;
        bus.fwd_valid  = 1'b0;
        bus.grad_valid = 1'b0;
    endtask

    task automatic do_reset(input bit fv, input bit gv);
        rst_n          = 1'b1;
        bus.fwd_valid  = fv;
        bus.fwd_data   = 8'h33;
        bus.grad_valid = gv;
        bus.grad_in    = 8'h55;
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.fwd_valid  = 1'b0;
        bus.grad_valid = 1'b0;
        model_cnt = 0;
        mask_q.delete();
        exp_q.delete();
        last_out = 8'h00;
        exp_vld  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        n_checks++; if (bus.fwd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fwd_ready got %b want 1", bus.fwd_ready); end
        n_checks++; if (bus.grad_ready !== 1'b0) begin n_fail++; $display("FAIL reset_grad_ready got %b want 0", bus.grad_ready); end
        n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_checks++; if (bus.grad_out !== 8'h00) begin n_fail++; $display("FAIL reset_grad_out got %h want 00", bus.grad_out); end
        n_checks++; if (bus.grad_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.grad_out_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] fds [3] = '{8'h05, 8'hFB, 8'h00};
        logic [7:0] gis [3] = '{8'h10, 8'h20, 8'h30};
        logic [7:0] req [3] = '{8'h10, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) step(1'b1, fds[i], 1'b0, 8'h00);
        n_checks++; if (bus.level !== 5'd3) begin n_fail++; $display("FAIL basic_level_full got %0d want 3", bus.level); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, i < 3, (i < 3) ? gis[i] : 8'h00);
            n_checks++; if (bus.grad_out_valid !== exp_vld) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want %b", i, bus.grad_out_valid, exp_vld); end
            if (exp_vld) last_out = exp_q.pop_front();
            n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL basic_out[%0d] got %h want %h", i, bus.grad_out, last_out); end
            if (i < 3) begin
                n_checks++; if (bus.grad_out !== req[i]) begin n_fail++; $display("FAIL basic_req[%0d] got %h want %h", i, bus.grad_out, req[i]); end
            end
        end
        n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL basic_level_empty got %0d want 0", bus.level); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h01, 1'b0, 8'h00);
        n_checks++; if (bus.fwd_ready !== 1'b0) begin n_fail++; $display("FAIL full_fwd_ready got %b want 0", bus.fwd_ready); end
        n_checks++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d want 16", bus.level); end
        step(1'b1, 8'h81, 1'b0, 8'h00);
        n_checks++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL full_17th_level got %0d want 16", bus.level); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(8'h80 + i * 7));
            n_checks++; if (bus.grad_out_valid !== exp_vld) begin n_fail++; $display("FAIL full_valid[%0d] got %b want %b", i, bus.grad_out_valid, exp_vld); end
            if (exp_vld) last_out = exp_q.pop_front();
            n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL full_out[%0d] got %h want %h", i, bus.grad_out, last_out); end
            if (i == 0) begin
                n_checks++; if (bus.fwd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", bus.fwd_ready); end
            end
        end
        n_checks++; if (bus.grad_ready !== 1'b0) begin n_fail++; $display("FAIL full_drained_grad_ready got %b want 0", bus.grad_ready); end
    endtask

    task automatic test_empty_stall();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h7F);
            n_checks++; if (bus.grad_ready !== 1'b0) begin n_fail++; $display("FAIL stall_grad_ready[%0d] got %b want 0", i, bus.grad_ready); end
            n_checks++; if (bus.grad_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 0", i, bus.grad_out_valid); end
            n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, bus.grad_out, last_out); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) step(1'b1, (i % 2) ? 8'h10 : 8'hF0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h22, 1'b1, 8'(8'h40 + i));
            n_checks++; if (bus.level !== 5'd15) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d want 15", i, bus.level); end
            n_checks++; if (bus.grad_out_valid !== exp_vld) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want %b", i, bus.grad_out_valid, exp_vld); end
            if (exp_vld) last_out = exp_q.pop_front();
            n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL b2b_out[%0d] got %h want %h", i, bus.grad_out, last_out); end
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(8'hC3 ^ i));
            if (exp_vld) last_out = exp_q.pop_front();
            n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL drain_out[%0d] got %h want %h", i, bus.grad_out, last_out); end
        end
        n_checks++; if (bus.level !== 5'(model_cnt)) begin n_fail++; $display("FAIL drain_level got %0d want %0d", bus.level, model_cnt); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'h7F, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 8'h66);
        last_out = exp_q.pop_front();
        do_reset(1'b1, 1'b1);
        n_checks++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL mrst_level got %0d want 0", bus.level); end
        n_checks++; if (bus.grad_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_grad_ready got %b want 0", bus.grad_ready); end
        n_checks++; if (bus.grad_out !== 8'h00) begin n_fail++; $display("FAIL mrst_grad_out got %h want 00", bus.grad_out); end
        n_checks++; if (bus.grad_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got %b want 0", bus.grad_out_valid); end
        step(1'b1, 8'hFE, 1'b0, 8'h00);
        n_checks++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL mrst_push_level got %0d want 1", bus.level); end
        step(1'b0, 8'h00, 1'b1, 8'h44);
        if (exp_vld) last_out = exp_q.pop_front();
        n_checks++; if (bus.grad_out_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_pop_valid got %b want 1", bus.grad_out_valid); end
        n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL mrst_pop_out got %h want %h", bus.grad_out, last_out); end
    endtask

    task automatic test_leaky();
        logic [7:0] req;
`ifdef RELU_GRAD_LEAKY_EN
        req = 8'hFC;
`else
        req = 8'h00;
`endif
        step(1'b1, 8'h80, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 8'hE0);
        if (exp_vld) last_out = exp_q.pop_front();
        n_checks++; if (bus.grad_out_valid !== 1'b1) begin n_fail++; $display("FAIL leaky_valid got %b want 1", bus.grad_out_valid); end
        n_checks++; if (bus.grad_out !== req) begin n_fail++; $display("FAIL leaky_out got %h want %h", bus.grad_out, req); end
        n_checks++; if (bus.grad_out !== last_out) begin n_fail++; $display("FAIL leaky_model got %h want %h", bus.grad_out, last_out); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        bus.fwd_valid  = 1'b0;
        bus.fwd_data   = 8'h00;
        bus.grad_valid = 1'b0;
        bus.grad_in    = 8'h00;
        model_cnt      = 0;
        last_out       = 8'h00;
        exp_vld        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_full();
        test_empty_stall();
        test_back_to_back();
        test_mid_reset();
        test_leaky();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
